// File: rtl/quad_gen.sv
// Quadrature encoder generator: walks a modular position toward an accepted target,
// emitting Gray-coded A/B phases every STEP_DIV clocks. Optional index pulse via QGEN_INDEX_EN.
module quad_gen #(
  parameter int STEP_DIV = 2500,
  parameter int POS_W    = 6
) (
  input  logic             pxl_clk,
  input  logic             reset,
  input  logic [POS_W-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic             done,
  output logic [POS_W-1:0] position,
  output logic             enc_a,
  output logic             enc_b,
  output logic             enc_c
);

  localparam int               DIV_W    = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic {
    IDLE,
    MOVE
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   tgt_q, tgt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               done_q, done_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic [POS_W-1:0]   delta;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pos_d   = pos_q;
    div_d   = div_q;
    done_d  = 1'b0;
    delta   = tgt_q - pos_q;

    case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d = target;
          if (target == pos_q) begin
            done_d = 1'b1;
          end else begin
            state_d = MOVE;
            div_d   = '0;
          end
        end
      end
      MOVE: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          // MSB of the modular distance picks the shorter way round; exactly half-way goes down.
          pos_d = delta[POS_W-1] ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
          if (pos_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Phase is a pure function of the low position bits: 0->00, 1->01, 2->11, 3->10.
    a_d = pos_d[1];
    b_d = pos_d[1] ^ pos_d[0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      pos_q   <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign target_ready = (state_q == IDLE);
  assign done         = done_q;
  assign position     = pos_q;
  assign enc_a        = a_q;
  assign enc_b        = b_q;

`ifdef QGEN_INDEX_EN
  logic             step;
  logic             c_q, c_d;
  logic [DIV_W-1:0] idx_cnt_q, idx_cnt_d;

  assign step = (state_q == MOVE) && (div_q == DIV_LAST);

  // Index is held for one step period after landing on zero, whether or not the move continues.
  always_comb begin
    c_d       = c_q;
    idx_cnt_d = idx_cnt_q;
    if (step && (pos_d == '0)) begin
      c_d       = 1'b1;
      idx_cnt_d = '0;
    end else if (c_q) begin
      if (idx_cnt_q == DIV_LAST) begin
        c_d       = 1'b0;
        idx_cnt_d = '0;
      end else begin
        idx_cnt_d = idx_cnt_q + DIV_ONE;
      end
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      c_q       <= 1'b0;
      idx_cnt_q <= '0;
    end else begin
      c_q       <= c_d;
      idx_cnt_q <= idx_cnt_d;
    end
  end

  assign enc_c = c_q;
`else
  assign enc_c = 1'b0;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen (STEP_DIV=4): directed moves, reset abort, and a
// closed loop through a behavioural quadrature decoder, with a done-time scoreboard.
module tb_quad_gen;

  localparam int SD = 4;

  logic       pxl_clk = 1'b0;
  logic       reset;
  logic [5:0] target;
  logic       target_valid;
  logic       target_ready;
  logic       done;
  logic [5:0] position;
  logic       enc_a, enc_b, enc_c;

  quad_gen #(.STEP_DIV(SD), .POS_W(6)) dut (
    .pxl_clk      (pxl_clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .done         (done),
    .position     (position),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .enc_c        (enc_c)
  );

  always #5 pxl_clk = ~pxl_clk;

  typedef struct {
    logic [5:0] pos;
    int         cycles;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         idx_until = -1;
  logic [5:0] model_pos = '0;
  logic [5:0] dec_pos = '0;
  logic [1:0] prev_ab = 2'b00;
  logic       rst_at_edge = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_ab(input logic [5:0] p);
    case (p[1:0])
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic tick();
    @(posedge pxl_clk);
    #1;
  endtask

  always @(posedge pxl_clk) begin
    cyc++;
    rst_at_edge = reset;
  end

  // Behavioural decoder: counts Gray transitions, flags any multi-bit jump outside reset.
  always @(negedge pxl_clk) begin
    logic [1:0] cur;
    logic [1:0] d;
    cur = {enc_a, enc_b};
    if (rst_at_edge) begin
      dec_pos = '0;
      prev_ab = cur;
    end else if (cur !== prev_ab) begin
      check("ab_one_bit", $countones(cur ^ prev_ab), 1);
      d = gidx(cur) - gidx(prev_ab);
      if (d == 2'd1) dec_pos = dec_pos + 6'd1;
      else if (d == 2'd3) dec_pos = dec_pos - 6'd1;
      prev_ab = cur;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    target_valid = 1'b0;
    tick();
    reset = 1'b0;
    model_pos = '0;
    idx_until = -1;
    sb_q.delete();
    check("rst_position", position, 6'd0);
    check("rst_ab", {enc_a, enc_b}, 2'b00);
    check("rst_c", enc_c, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", target_ready, 1'b1);
  endtask

  task automatic do_move(input logic [5:0] tgt);
    logic [5:0] start;
    logic [5:0] delta;
    logic [5:0] cur;
    logic       up;
    logic       exp_c;
    int         n;
    exp_t       e;
    start = model_pos;
    delta = tgt - start;
    up    = (delta < 6'd32);
    n     = up ? int'(delta) : 64 - int'(delta);

    target       = tgt;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    sb_q.push_back('{pos: tgt, cycles: n * SD});
    check("ready_after_accept", target_ready, n == 0);

    for (int k = 0; k <= n * SD; k++) begin
      cur = up ? start + 6'(k / SD) : start - 6'(k / SD);
      if (k > 0 && (k % SD) == 0 && cur == 6'd0) idx_until = cyc + SD - 1;
`ifdef QGEN_INDEX_EN
      exp_c = (cyc <= idx_until);
`else
      exp_c = 1'b0;
`endif
      check("ab", {enc_a, enc_b}, exp_ab(cur));
      check("position", position, cur);
      check("enc_c", enc_c, exp_c);
      check("done", done, k == n * SD);
      if (done) begin
        e = sb_q.pop_front();
        check("done_pos", position, e.pos);
        check("done_cycles", k, e.cycles);
        check("ready_at_done", target_ready, 1'b1);
        @(negedge pxl_clk);
        #1;
        check("decoder_pos", dec_pos, e.pos);
        break;
      end
      if (k < n * SD) tick();
    end
    check("done_seen", sb_q.size(), 0);
    sb_q.delete();
    model_pos = tgt;
  endtask

  initial begin
    target       = '0;
    target_valid = 1'b0;
    reset        = 1'b1;
    tick();
    do_reset();

    do_move(6'd5);   // up 5
    do_move(6'd2);   // down 3
    do_move(6'd60);  // down 6 through 0 and 63
    do_move(6'd0);   // up 4, lands on index
    do_move(6'd32);  // delta exactly 32 goes down
    do_move(6'd32);  // equal target: no edges

    // Abort a move at position 3 (AB=10) with reset.
    do_reset();
    target       = 6'd10;
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    repeat (3 * SD) tick();
    check("pre_abort_pos", position, 6'd3);
    check("pre_abort_ab", {enc_a, enc_b}, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_pos = '0;
    idx_until = -1;
    check("abort_pos", position, 6'd0);
    check("abort_ab", {enc_a, enc_b}, 2'b00);
    check("abort_ready", target_ready, 1'b1);
    check("abort_done", done, 1'b0);
    repeat (SD + 1) begin
      tick();
      check("abort_no_done", done, 1'b0);
      check("abort_idle_pos", position, 6'd0);
    end

    // Closed loop: random targets with random request gaps (including back-to-back).
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(3)) tick();
      do_move(6'($urandom_range(63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
